// File: rtl/uart_rx_parser_pkg.sv
// Shared constants, state encodings and the ASCII hex decoder used by the
// SFP status-frame receiver.
package uart_rx_parser_pkg;

    localparam int CLKS_PER_BIT = 4167;
    localparam int FRAME_LEN    = 18;
    localparam int NUM_BYTES    = FRAME_LEN / 3;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic       {PS_HUNT, PS_RUN} prs_state_e;

    // Returns {valid, nibble}; only '0'-'9' and 'A'-'F' are accepted.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if (c >= 8'h41 && c <= 8'h46)
            return {1'b1, c[3:0] + 4'd9};
        else
            return 5'd0;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, start/data/stop FSM and baud counter.
// Byte and framing-error strobes are registered, one cycle after the stop sample.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = uart_rx_parser_pkg::CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_uart_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_vld,
    output logic       o_frame_err
);
    import uart_rx_parser_pkg::*;

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    rx_state_e     state_q, state_d;
    logic [1:0]    sync_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          vld_q, vld_d, ferr_q, ferr_d;
    logic          rx;

    assign rx = sync_q[1];

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], i_uart_rx};
            prev_q  <= rx;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx) begin
                    state_d = RX_START;
                    bit_d   = '0;
                end
            end
            RX_START: begin
                // A line that is high again at mid-start-bit was noise.
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    vld_d   = rx;
                    ferr_d  = !rx;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign o_byte      = shift_q;
    assign o_byte_vld  = vld_q;
    assign o_frame_err = ferr_q;

endmodule

// File: rtl/uart_rx_parser.sv
// Parses "HH HH HH HH HH HH<CR>" frames into six status bytes, published
// atomically on a correct CR; bad characters and framing errors are counted.
module uart_rx_parser #(
    parameter int CLKS_PER_BIT = uart_rx_parser_pkg::CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_uart_rx,
    output logic [7:0] o_reg_1,
    output logic [7:0] o_reg_2,
    output logic [7:0] o_reg_3,
    output logic [7:0] o_reg_4,
    output logic [7:0] o_reg_5,
    output logic [7:0] o_reg_6,
    output logic       o_valid,
    output logic       o_err,
    output logic [7:0] o_err_cnt
);
    import uart_rx_parser_pkg::*;

    logic [7:0] rx_byte;
    logic       rx_vld, rx_ferr;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_clk       (i_clk),
        .i_res       (i_res),
        .i_uart_rx   (i_uart_rx),
        .o_byte      (rx_byte),
        .o_byte_vld  (rx_vld),
        .o_frame_err (rx_ferr)
    );

    prs_state_e                  state_q, state_d;
    logic [1:0]                  phase_q, phase_d;
    logic [2:0]                  idx_q, idx_d;
    logic [NUM_BYTES-1:0][7:0]   shadow_q, shadow_d, out_q, out_d;
    logic                        valid_q, valid_d, err_q, err_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic [4:0]                  nib;
    logic                        last;

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state_q  <= PS_HUNT;
            phase_q  <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        nib      = hex_decode(rx_byte);
        last     = (idx_q == 3'(NUM_BYTES - 1)) && (phase_q == 2'd2);

        if (rx_ferr) begin
            if (state_q == PS_RUN) begin
                err_d   = 1'b1;
                state_d = PS_HUNT;
            end
        end else if (rx_vld) begin
            case (state_q)
                PS_HUNT: begin
                    if (rx_byte == ASCII_CR) begin
                        state_d = PS_RUN;
                        phase_d = '0;
                        idx_d   = '0;
                    end
                end
                PS_RUN: begin
                    // Any CR restarts the frame; only one at the last slot publishes.
                    if (rx_byte == ASCII_CR) begin
                        phase_d = '0;
                        idx_d   = '0;
                        if (last) begin
                            out_d   = shadow_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (phase_q == 2'd2) begin
                        if (rx_byte == ASCII_SP && !last) begin
                            phase_d = '0;
                            idx_d   = idx_q + 3'd1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = PS_HUNT;
                        end
                    end else if (nib[4]) begin
                        if (phase_q == 2'd0)
                            shadow_d[idx_q][7:4] = nib[3:0];
                        else
                            shadow_d[idx_q][3:0] = nib[3:0];
                        phase_d = phase_q + 2'd1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = PS_HUNT;
                    end
                end
                default: state_d = PS_HUNT;
            endcase
        end

        if (err_d && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    assign o_reg_1   = out_q[0];
    assign o_reg_2   = out_q[1];
    assign o_reg_3   = out_q[2];
    assign o_reg_4   = out_q[3];
    assign o_reg_5   = out_q[4];
    assign o_reg_6   = out_q[5];
    assign o_valid   = valid_q;
    assign o_err     = err_q;
    assign o_err_cnt = cnt_q;

endmodule

// File: tb/tb_uart_rx_parser.sv
// Self-checking bench for uart_rx_parser with a shortened bit time; accepted
// frames are scoreboarded against a queue of expected byte sextets.
module tb_uart_rx_parser;

    localparam int CPB  = 12;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] o_reg_1, o_reg_2, o_reg_3, o_reg_4, o_reg_5, o_reg_6;
    logic       o_valid, o_err;
    logic [7:0] o_err_cnt;
    logic [47:0] got;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int last_valid_cyc = -1;
    int last_start = 0;
    logic [47:0] exp_q[$];

    uart_rx_parser #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk     (clk),
        .i_res     (res),
        .i_uart_rx (rx),
        .o_reg_1   (o_reg_1),
        .o_reg_2   (o_reg_2),
        .o_reg_3   (o_reg_3),
        .o_reg_4   (o_reg_4),
        .o_reg_5   (o_reg_5),
        .o_reg_6   (o_reg_6),
        .o_valid   (o_valid),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt)
    );

    assign got = {o_reg_1, o_reg_2, o_reg_3, o_reg_4, o_reg_5, o_reg_6};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every o_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        logic [47:0] e;
        if (o_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got %h, no frame expected", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL frame_data: got %h expected %h", got, e);
                end
            end
            checks++;
            if (o_err !== 1'b0) begin
                errors++;
                $display("FAIL valid_err_overlap: o_err %b expected 0", o_err);
            end
        end
        if (o_err) n_err++;
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        last_start = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic test_reset;
        res = 1'b1;
        idle(5);
        res = 1'b0;
        idle(2);
        checks++;
        if (got !== 48'h0) begin errors++; $display("FAIL reset_regs: got %h expected 0", got); end
        checks++;
        if ({o_valid, o_err} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {o_valid, o_err}); end
        checks++;
        if (o_err_cnt !== 8'h00) begin errors++; $display("FAIL reset_errcnt: got %h expected 00", o_err_cnt); end
    endtask

    task automatic test_hunt_sync;
        send_str("12 34 56 78 9A BC\r");
        idle(2 * CPB);
        checks++;
        if (n_valid !== 0) begin errors++; $display("FAIL hunt_first_frame: valid count %0d expected 0", n_valid); end
        exp_q.push_back(48'h123456789ABC);
        send_str("12 34 56 78 9A BC\r");
        idle(2 * CPB);
        checks++;
        if (n_valid !== 1) begin errors++; $display("FAIL sync_second_frame: valid count %0d expected 1", n_valid); end
        checks++;
        if (o_err_cnt !== 8'h00 || n_err !== 0) begin errors++; $display("FAIL sync_no_err: errcnt %h pulses %0d expected 0", o_err_cnt, n_err); end
    endtask

    // Expected pulse: 2 synchroniser flops + edge register, half a bit to
    // mid-start, 9 more bits to mid-stop, then the 2-cycle output latency.
    task automatic test_latency;
        int v0;
        v0 = n_valid;
        exp_q.push_back(48'hFF00A55A0FF0);
        send_str("FF 00 A5 5A 0F F0\r");
        idle(2 * CPB);
        checks++;
        if (n_valid !== v0 + 1) begin errors++; $display("FAIL latency_count: valid count %0d expected %0d", n_valid, v0 + 1); end
        checks++;
        if (last_valid_cyc !== last_start + 4 + HALF + 9 * CPB) begin
            errors++;
            $display("FAIL latency_cycle: valid at %0d expected %0d", last_valid_cyc, last_start + 4 + HALF + 9 * CPB);
        end
    endtask

    task automatic test_bad_hex;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_str("1G 00 00 00 00 00\r");
        idle(2 * CPB);
        checks++;
        if (n_err !== e0 + 1 || o_err_cnt !== 8'd1) begin errors++; $display("FAIL badhex_err: pulses %0d cnt %h expected %0d / 01", n_err, o_err_cnt, e0 + 1); end
        checks++;
        if (got !== 48'hFF00A55A0FF0 || n_valid !== v0) begin errors++; $display("FAIL badhex_hold: got %h expected ff00a55a0ff0", got); end
        exp_q.push_back(48'h010203040506);
        send_str("01 02 03 04 05 06\r");
        idle(2 * CPB);
        checks++;
        if (n_valid !== v0 + 1) begin errors++; $display("FAIL badhex_recover: valid count %0d expected %0d", n_valid, v0 + 1); end
    endtask

    task automatic test_framing;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_str("11 2");
        send_byte(8'h32, 1'b0);
        idle(2 * CPB);
        checks++;
        if (n_err !== e0 + 1 || o_err_cnt !== 8'd2) begin errors++; $display("FAIL framing_err: pulses %0d cnt %h expected %0d / 02", n_err, o_err_cnt, e0 + 1); end
        send_str("AB CD EF 01 23 45\r");
        idle(2 * CPB);
        checks++;
        if (n_valid !== v0 || got !== 48'h010203040506) begin errors++; $display("FAIL framing_drop: valid count %0d regs %h expected %0d / 010203040506", n_valid, got, v0); end
        exp_q.push_back(48'h0A0B0C0D0E0F);
        send_str("0A 0B 0C 0D 0E 0F\r");
        idle(2 * CPB);
        checks++;
        if (n_valid !== v0 + 1) begin errors++; $display("FAIL framing_recover: valid count %0d expected %0d", n_valid, v0 + 1); end
    endtask

    task automatic test_glitch;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        rx = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        idle(3 * CPB);
        checks++;
        if (n_valid !== v0 || n_err !== e0 || o_err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL glitch: valid %0d err %0d cnt %h expected %0d %0d 02", n_valid, n_err, o_err_cnt, v0, e0);
        end
    endtask

    task automatic test_reset_mid;
        int v0;
        send_str("12 34 5");
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
        res = 1'b1;
        idle(3);
        checks++;
        if (got !== 48'h0 || o_err_cnt !== 8'h00 || {o_valid, o_err} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_outputs: regs %h cnt %h strobes %b expected 0", got, o_err_cnt, {o_valid, o_err});
        end
        res = 1'b0;
        idle(2 * CPB);
        v0 = n_valid;
        send_str("21 43 65 87 A9 CB\r");
        idle(2 * CPB);
        checks++;
        if (n_valid !== v0 || got !== 48'h0) begin errors++; $display("FAIL midreset_hunt: valid count %0d regs %h expected %0d / 0", n_valid, got, v0); end
        exp_q.push_back(48'hDEADBEEF0011);
        send_str("DE AD BE EF 00 11\r");
        idle(2 * CPB);
        checks++;
        if (n_valid !== v0 + 1) begin errors++; $display("FAIL midreset_recover: valid count %0d expected %0d", n_valid, v0 + 1); end
    endtask

    // In RUN at p=0 every CR is an early CR: one error each, still in sync.
    task automatic test_saturate;
        int e0;
        e0 = n_err;
        for (int i = 0; i < 254; i++) send_byte(8'h0D, 1'b1);
        idle(CPB);
        checks++;
        if (o_err_cnt !== 8'hFE) begin errors++; $display("FAIL sat_254: cnt %h expected fe", o_err_cnt); end
        send_byte(8'h0D, 1'b1);
        idle(CPB);
        checks++;
        if (o_err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_255: cnt %h expected ff", o_err_cnt); end
        for (int i = 0; i < 45; i++) send_byte(8'h0D, 1'b1);
        idle(CPB);
        checks++;
        if (o_err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold: cnt %h expected ff", o_err_cnt); end
        checks++;
        if (n_err !== e0 + 300) begin errors++; $display("FAIL sat_pulses: pulses %0d expected %0d", n_err - e0, 300); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_hunt_sync();
        test_latency();
        test_bad_hex();
        test_framing();
        test_glitch();
        test_reset_mid();
        test_saturate();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d frames left expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
